// File: rtl/bitstream_decimator_pkg.sv
// bitstream_decimator_pkg
// Shared constants and helpers for the delta-sigma decimation chain.
// Holds the default oversampling ratio, output width and synchronizer depth,
// plus the width helper that later filter stages reuse to size their outputs.
package bitstream_decimator_pkg;

   localparam int DEFAULT_OSR          = 256;
   localparam int DEFAULT_SAMPLE_WIDTH = 9;
   localparam int DEFAULT_SYNC_STAGES  = 2;

   // Bits needed to hold any count in 0..maxCount, i.e. clog2(maxCount+1).
   // With maxCount = OSR this is the minimum legal sample width.
   function automatic int sampleWidth(input int maxCount);
      return $clog2(maxCount + 1);
   endfunction

endpackage

// File: rtl/bitstream_decimator_sync_edge_detect.sv
// sync_edge_detect
// Brings the divided sample clock and the modulator bit into the clk domain
// through equal-length synchronizer chains, then produces a one-cycle tick on
// each rising edge of the synchronized sample clock, together with the
// modulator bit captured alongside that edge.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   slowClock  divided sample clock, asynchronous level
//   bitIn      modulator bitstream
//   tick       one-cycle pulse per armed rising edge of slowClock
//   bitSample  synchronized bitIn, valid while tick is high
module sync_edge_detect
   import bitstream_decimator_pkg::*;
#(
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic slowClock,
   input  logic bitIn,
   output logic tick,
   output logic bitSample
);

   logic [SYNC_STAGES-1:0] clockChain;
   logic [SYNC_STAGES-1:0] bitChain;
   logic [SYNC_STAGES-1:0] fillChain;
   logic                   clockPrev;
   logic                   armed;
   logic                   clockSync;
   logic                   bitSync;
   logic                   chainFull;

   assign clockSync = clockChain[SYNC_STAGES-1];
   assign bitSync   = bitChain[SYNC_STAGES-1];
   assign chainFull = fillChain[SYNC_STAGES-1];

   // Synchronizers, edge register and arming logic.
   // The reset value of the clock chain is 0, which would look like a genuine
   // low phase right after reset and arm the detector too early, turning a
   // slowClock that is already high into a false edge. fillChain marks when the
   // chain holds only sampled port values, and arming waits for it.
   // The tick and its bit are registered together so they stay aligned and
   // the tick appears SYNC_STAGES+1 cycles after the port rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         clockChain <= '0;
         bitChain   <= '0;
         fillChain  <= '0;
         clockPrev  <= 1'b0;
         armed      <= 1'b0;
         tick       <= 1'b0;
         bitSample  <= 1'b0;
      end else begin
         clockChain <= {clockChain[SYNC_STAGES-2:0], slowClock};
         bitChain   <= {bitChain[SYNC_STAGES-2:0], bitIn};
         fillChain  <= {fillChain[SYNC_STAGES-2:0], 1'b1};
         clockPrev  <= clockSync;
         if (chainFull && !clockSync) begin
            armed <= 1'b1;
         end
         tick      <= armed && clockSync && !clockPrev;
         bitSample <= bitSync;
      end
   end

endmodule

// File: rtl/bitstream_decimator.sv
// bitstream_decimator
// Sinc1 (boxcar) decimator for a 1-bit delta-sigma stream. Counts the ones
// seen over OSR rising edges of the divided sample clock and presents each
// window's count over a valid/ready handshake. A window that completes while
// the previous sample is still unaccepted is dropped and flagged in overrun.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   slowClock    divided sample clock, asynchronous level
//   bitIn        modulator bitstream
//   sampleOut    ones counted in the last window, unsigned
//   sampleValid  sampleOut holds an unaccepted sample
//   sampleReady  downstream accepts when sampleValid && sampleReady
//   overrun      sticky flag, a completed window was dropped
module bitstream_decimator
   import bitstream_decimator_pkg::*;
#(
   parameter int OSR          = DEFAULT_OSR,
   parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
   parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    slowClock,
   input  logic                    bitIn,
   output logic [SAMPLE_WIDTH-1:0] sampleOut,
   output logic                    sampleValid,
   input  logic                    sampleReady,
   output logic                    overrun
);

   // The edge counter only has to reach OSR-1; OSR=1 still needs one bit.
   localparam int COUNT_WIDTH = (OSR > 1) ? sampleWidth(OSR - 1) : 1;
   localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(OSR - 1);

   logic                    tick;
   logic                    bitSample;
   logic [COUNT_WIDTH-1:0]  edgeCount;
   logic [SAMPLE_WIDTH-1:0] accumulator;
   logic [SAMPLE_WIDTH-1:0] bitWide;
   logic [SAMPLE_WIDTH-1:0] result;
   logic                    windowDone;
   logic                    loadSample;
   logic                    dropSample;
   logic                    accepted;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) edgeDetect (
      .clk       (clk),
      .rst       (rst),
      .slowClock (slowClock),
      .bitIn     (bitIn),
      .tick      (tick),
      .bitSample (bitSample)
   );

   // Window bookkeeping. The final bit of a window is folded into result
   // directly rather than into the accumulator, so the accumulator can be
   // cleared in the same cycle and the next window starts on the next tick.
   // A completed window loads the output register when it is empty or being
   // emptied in this very cycle; otherwise it is dropped.
   always_comb begin
      bitWide    = '0;
      bitWide[0] = bitSample;
      result     = accumulator + bitWide;
      windowDone = tick && (edgeCount == LAST_COUNT);
      accepted   = sampleValid && sampleReady;
      loadSample = windowDone && (!sampleValid || sampleReady);
      dropSample = windowDone && sampleValid && !sampleReady;
   end

   // Edge counter and accumulator, advanced once per tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         edgeCount   <= '0;
         accumulator <= '0;
      end else if (tick) begin
         if (windowDone) begin
            edgeCount   <= '0;
            accumulator <= '0;
         end else begin
            edgeCount   <= edgeCount + COUNT_WIDTH'(1);
            accumulator <= result;
         end
      end
   end

   // Output register and handshake. A load takes priority over a plain
   // acceptance so a simultaneous accept-and-load keeps sampleValid high.
   // overrun is sticky until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sampleOut   <= '0;
         sampleValid <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (loadSample) begin
            sampleOut   <= result;
            sampleValid <= 1'b1;
         end else if (accepted) begin
            sampleValid <= 1'b0;
         end
         if (dropSample) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bitstream_decimator.sv
// tb_bitstream_decimator
// Directed bench for bitstream_decimator. Three instances (OSR 256, 8 and 4)
// share clock, reset, slowClock and bitIn; each has its own sampleReady.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bitstream_decimator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       slowClock = 1'b1;
   logic       bitIn = 1'b0;

   logic       ready256 = 1'b0;
   logic       ready8 = 1'b0;
   logic       ready4 = 1'b0;

   logic [8:0] out256;
   logic       valid256;
   logic       overrun256;
   logic [3:0] out8;
   logic       valid8;
   logic       overrun8;
   logic [2:0] out4;
   logic       valid4;
   logic       overrun4;

   int checkCount = 0;
   int passCount  = 0;

   localparam int FAST_HALF = 4;

   // 100 MHz system clock.
   always #5 clk = ~clk;

   bitstream_decimator #(.OSR(256), .SAMPLE_WIDTH(9), .SYNC_STAGES(2)) dut256 (
      .clk(clk), .rst(rst), .slowClock(slowClock), .bitIn(bitIn),
      .sampleOut(out256), .sampleValid(valid256), .sampleReady(ready256), .overrun(overrun256)
   );

   bitstream_decimator #(.OSR(8), .SAMPLE_WIDTH(4), .SYNC_STAGES(2)) dut8 (
      .clk(clk), .rst(rst), .slowClock(slowClock), .bitIn(bitIn),
      .sampleOut(out8), .sampleValid(valid8), .sampleReady(ready8), .overrun(overrun8)
   );

   bitstream_decimator #(.OSR(4), .SAMPLE_WIDTH(3), .SYNC_STAGES(2)) dut4 (
      .clk(clk), .rst(rst), .slowClock(slowClock), .bitIn(bitIn),
      .sampleOut(out4), .sampleValid(valid4), .sampleReady(ready4), .overrun(overrun4)
   );

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One full slowClock period: low phase with the new bit, then the rise.
   task automatic applyStimulus(input logic b, input int half);
      bitIn     = b;
      slowClock = 1'b0;
      waitCycles(half);
      slowClock = 1'b1;
      waitCycles(half);
   endtask

   // Reset pulse with slowClock low so every instance arms straight away.
   task automatic pulseReset();
      slowClock = 1'b0;
      rst = 1'b1;
      waitCycles(3);
      rst = 1'b0;
      waitCycles(4);
   endtask

   task automatic test_reset();
      ready256 = 1'b0; ready8 = 1'b0; ready4 = 1'b0;
      slowClock = 1'b1;
      rst = 1'b1;
      waitCycles(3);
      checkCount++;
      if (valid8 !== 1'b0) $display("[TB] FAIL reset_valid: got %0b want 0", valid8); else passCount++;
      checkCount++;
      if (out8 !== 4'd0) $display("[TB] FAIL reset_out: got %0d want 0", out8); else passCount++;
      checkCount++;
      if (overrun8 !== 1'b0) $display("[TB] FAIL reset_overrun: got %0b want 0", overrun8); else passCount++;
      // slowClock already high at release must not count as an edge.
      rst = 1'b0;
      waitCycles(20);
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 51);
      checkCount++;
      if (valid8 !== 1'b0) $display("[TB] FAIL arm_no_false_edge: got valid %0b want 0", valid8); else passCount++;
      applyStimulus(1'b1, 51);
      checkCount++;
      if (valid8 !== 1'b1) $display("[TB] FAIL arm_window_valid: got %0b want 1", valid8); else passCount++;
      checkCount++;
      if (out8 !== 4'd8) $display("[TB] FAIL arm_window_out: got %0d want 8", out8); else passCount++;
   endtask

   task automatic test_all_ones_zeros();
      ready256 = 1'b0;
      pulseReset();
      for (int i = 0; i < 255; i++) applyStimulus(1'b1, FAST_HALF);
      checkCount++;
      if (valid256 !== 1'b0) $display("[TB] FAIL ones_early_valid: got %0b want 0", valid256); else passCount++;
      // 256th edge: tick lands 3 cycles after the rise, valid one cycle later.
      bitIn = 1'b1;
      slowClock = 1'b0;
      waitCycles(FAST_HALF);
      slowClock = 1'b1;
      waitCycles(3);
      checkCount++;
      if (valid256 !== 1'b0) $display("[TB] FAIL ones_latency_early: got %0b want 0", valid256); else passCount++;
      waitCycles(1);
      checkCount++;
      if (valid256 !== 1'b1) $display("[TB] FAIL ones_latency_valid: got %0b want 1", valid256); else passCount++;
      checkCount++;
      if (out256 !== 9'd256) $display("[TB] FAIL ones_out: got %0d want 256", out256); else passCount++;
      ready256 = 1'b1;
      waitCycles(1);
      ready256 = 1'b0;
      checkCount++;
      if (valid256 !== 1'b0) $display("[TB] FAIL ones_accept_clear: got %0b want 0", valid256); else passCount++;
      for (int i = 0; i < 256; i++) applyStimulus(1'b0, FAST_HALF);
      checkCount++;
      if (valid256 !== 1'b1) $display("[TB] FAIL zeros_valid: got %0b want 1", valid256); else passCount++;
      checkCount++;
      if (out256 !== 9'd0) $display("[TB] FAIL zeros_out: got %0d want 0", out256); else passCount++;
   endtask

   task automatic test_pattern();
      logic [7:0] firstThree;
      firstThree = 8'b0000_0111;
      ready8 = 1'b0;
      pulseReset();
      for (int i = 0; i < 8; i++) applyStimulus((i % 2) == 0, FAST_HALF);
      checkCount++;
      if (valid8 !== 1'b1) $display("[TB] FAIL alt_valid: got %0b want 1", valid8); else passCount++;
      checkCount++;
      if (out8 !== 4'd4) $display("[TB] FAIL alt_out: got %0d want 4", out8); else passCount++;
      ready8 = 1'b1;
      waitCycles(1);
      ready8 = 1'b0;
      checkCount++;
      if (valid8 !== 1'b0) $display("[TB] FAIL alt_accept_clear: got %0b want 0", valid8); else passCount++;
      for (int i = 0; i < 8; i++) applyStimulus(firstThree[i], FAST_HALF);
      checkCount++;
      if (valid8 !== 1'b1) $display("[TB] FAIL three_valid: got %0b want 1", valid8); else passCount++;
      checkCount++;
      if (out8 !== 4'd3) $display("[TB] FAIL three_out: got %0d want 3", out8); else passCount++;
   endtask

   task automatic test_overrun();
      ready4 = 1'b0;
      pulseReset();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, FAST_HALF);
      checkCount++;
      if (out4 !== 3'd4 || valid4 !== 1'b1) $display("[TB] FAIL ovr_first: got out %0d valid %0b want 4/1", out4, valid4); else passCount++;
      checkCount++;
      if (overrun4 !== 1'b0) $display("[TB] FAIL ovr_not_yet: got %0b want 0", overrun4); else passCount++;
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, FAST_HALF);
      checkCount++;
      if (out4 !== 3'd4 || valid4 !== 1'b1) $display("[TB] FAIL ovr_held: got out %0d valid %0b want 4/1", out4, valid4); else passCount++;
      checkCount++;
      if (overrun4 !== 1'b1) $display("[TB] FAIL ovr_set: got %0b want 1", overrun4); else passCount++;
      ready4 = 1'b1;
      waitCycles(1);
      ready4 = 1'b0;
      checkCount++;
      if (valid4 !== 1'b0) $display("[TB] FAIL ovr_accept_clear: got %0b want 0", valid4); else passCount++;
      waitCycles(5);
      checkCount++;
      if (overrun4 !== 1'b1) $display("[TB] FAIL ovr_sticky: got %0b want 1", overrun4); else passCount++;
   endtask

   task automatic test_back_to_back();
      ready4 = 1'b0;
      pulseReset();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, FAST_HALF);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, FAST_HALF);
      checkCount++;
      if (out4 !== 3'd4 || valid4 !== 1'b1) $display("[TB] FAIL b2b_first: got out %0d valid %0b want 4/1", out4, valid4); else passCount++;
      // Final edge of the second window: ready goes high in the tick cycle.
      bitIn = 1'b0;
      slowClock = 1'b0;
      waitCycles(FAST_HALF);
      slowClock = 1'b1;
      waitCycles(3);
      ready4 = 1'b1;
      checkCount++;
      if (valid4 !== 1'b1) $display("[TB] FAIL b2b_valid_before: got %0b want 1", valid4); else passCount++;
      waitCycles(1);
      ready4 = 1'b0;
      checkCount++;
      if (valid4 !== 1'b1) $display("[TB] FAIL b2b_valid_kept: got %0b want 1", valid4); else passCount++;
      checkCount++;
      if (out4 !== 3'd0) $display("[TB] FAIL b2b_new_out: got %0d want 0", out4); else passCount++;
      checkCount++;
      if (overrun4 !== 1'b0) $display("[TB] FAIL b2b_overrun: got %0b want 0", overrun4); else passCount++;
   endtask

   task automatic test_reset_mid_window();
      ready8 = 1'b0;
      pulseReset();
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, FAST_HALF);
      rst = 1'b1;
      waitCycles(2);
      rst = 1'b0;
      waitCycles(2);
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, FAST_HALF);
      checkCount++;
      if (valid8 !== 1'b0) $display("[TB] FAIL mid_rst_early: got %0b want 0", valid8); else passCount++;
      applyStimulus(1'b1, FAST_HALF);
      checkCount++;
      if (valid8 !== 1'b1) $display("[TB] FAIL mid_rst_valid: got %0b want 1", valid8); else passCount++;
      checkCount++;
      if (out8 !== 4'd8) $display("[TB] FAIL mid_rst_out: got %0d want 8", out8); else passCount++;
   endtask

   initial begin
      waitCycles(1);
      test_reset();
      test_all_ones_zeros();
      test_pattern();
      test_overrun();
      test_back_to_back();
      test_reset_mid_window();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
